// File: rtl/music_player.sv
// music_player: steps a note ROM one entry per beat and drives a square-wave buzzer.
// Ports:
//   clk      - single clock for all state
//   rst_n    - asynchronous active-low reset
//   start    - one-cycle request to (re)start playback at address 0
//   stop     - one-cycle request to abort playback; wins over start and end of score
//   loop_en  - wrap to address 0 after LAST_ADDR instead of finishing
//   address  - note ROM address
//   note_in  - ROM data (tone half-period in clk cycles), valid one cycle after address
//   buzzer   - square-wave tone, f_clk/(2*period)
//   busy     - high while playing
//   done     - one-cycle pulse when a non-looping score ends
module music_player #(
  parameter int BEAT_CYC  = 12_500_000,
  parameter int LAST_ADDR = 383,
  parameter int REST_CODE = 2500,
  parameter int NOTE_W    = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [8:0]        address,
  input  logic [NOTE_W-1:0] note_in,
  output logic              buzzer,
  output logic              busy,
  output logic              done
);
  localparam int BW = BEAT_CYC > 1 ? $clog2(BEAT_CYC) : 1;
  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
  state_t            state;
  logic [BW-1:0]     beat_cnt;
  logic [NOTE_W-1:0] tone_cnt;
  logic [NOTE_W-1:0] period;
  logic              chg1;
  logic              chg2;
  logic              beat_end;
  logic              at_last;
  logic              new_silent;
  logic              cur_silent;
  logic              tone_clear;
  logic              tone_wrap;
  assign beat_end   = beat_cnt == BW'(BEAT_CYC - 1);
  assign at_last    = address == 9'(LAST_ADDR);
  assign new_silent = note_in == NOTE_W'(REST_CODE) || note_in == '0;
  assign cur_silent = period == NOTE_W'(REST_CODE) || period == '0;
  // a new note restarts the tone from phase 0; a repeated note keeps running so tied notes don't glitch
  assign tone_clear = chg2 ? (new_silent || note_in != period) : cur_silent;
  assign tone_wrap  = tone_cnt == period - NOTE_W'(1);
  // chg1: address just changed, ROM is fetching; chg2: ROM data on note_in, capture it now
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      address  <= '0;
      beat_cnt <= '0;
      tone_cnt <= '0;
      period   <= '0;
      buzzer   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      chg1     <= 1'b0;
      chg2     <= 1'b0;
    end else begin
      chg1 <= 1'b0;
      chg2 <= 1'b0;
      done <= 1'b0;
      if (stop || state == DONE) begin
        state    <= IDLE;
        busy     <= 1'b0;
        tone_cnt <= '0;
        buzzer   <= 1'b0;
      end else if (start) begin
        // period is cleared so the first capture always counts as a new note
        state    <= PLAY;
        busy     <= 1'b1;
        address  <= '0;
        beat_cnt <= '0;
        period   <= '0;
        tone_cnt <= '0;
        buzzer   <= 1'b0;
        chg1     <= 1'b1;
      end else if (state == PLAY) begin
        if (beat_end && at_last && !loop_en) begin
          state    <= DONE;
          busy     <= 1'b0;
          done     <= 1'b1;
          tone_cnt <= '0;
          buzzer   <= 1'b0;
        end else begin
          chg2     <= chg1;
          beat_cnt <= beat_end ? '0 : beat_cnt + BW'(1);
          if (beat_end) begin
            address <= at_last ? 9'd0 : address + 9'd1;
            chg1    <= 1'b1;
          end
          if (chg2)
            period <= note_in;
          if (tone_clear) begin
            tone_cnt <= '0;
            buzzer   <= 1'b0;
          end else if (tone_wrap) begin
            tone_cnt <= '0;
            buzzer   <= ~buzzer;
          end else
            tone_cnt <= tone_cnt + NOTE_W'(1);
        end
      end
    end
endmodule

// File: tb/tb_music_player.sv
// tb_music_player: randomized scoreboard bench for music_player against a timeline model.
module tb_music_player;
  localparam int BEAT  = 100;
  localparam int LAST  = 9;
  localparam int REST  = 2500;
  localparam int NW    = 17;
  localparam int TOTAL = (LAST + 1) * BEAT;
  typedef struct {
    int c;
    int addr;
    bit buz;
    bit bsy;
    bit dn;
  } exp_t;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic [8:0]    address;
  logic [NW-1:0] note_in = '0;
  logic          buzzer;
  logic          busy;
  logic          done;
  logic [NW-1:0] rom [512];
  int            cyc = 0;
  int            n_chk = 0;
  int            n_fail = 0;
  bit            end_req = 1'b0;
  exp_t          q[$];
  exp_t          me;

  music_player #(.BEAT_CYC(BEAT), .LAST_ADDR(LAST), .REST_CODE(REST), .NOTE_W(NW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .address(address), .note_in(note_in), .buzzer(buzzer), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) note_in <= rom[address];

  function automatic int note_at(int j);
    return int'(rom[j % (LAST + 1)]);
  endfunction

  function automatic bit silent(int n);
    return n == REST || n == 0;
  endfunction

  // expected outputs k edges after the edge that sampled start
  function automatic exp_t model(int e_s, int k, bit lp);
    exp_t e;
    int j, s, n;
    e.c = e_s + k;
    if (!lp && k >= TOTAL) begin
      e.addr = LAST;
      e.buz = 1'b0;
      e.bsy = 1'b0;
      e.dn = k == TOTAL;
      return e;
    end
    e.addr = (k / BEAT) % (LAST + 1);
    e.bsy = 1'b1;
    e.dn = 1'b0;
    e.buz = 1'b0;
    if (k >= 2) begin
      j = (k - 2) / BEAT;
      n = note_at(j);
      if (!silent(n)) begin
        s = j;
        while (s > 0 && note_at(s - 1) == n) s--;
        e.buz = (((k - s * BEAT - 2) / n) % 2) == 1;
      end
    end
    return e;
  endfunction

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic fill();
    for (int i = 0; i <= LAST; i++) rom[i] = NW'($urandom_range(1, 40));
    rom[7] = NW'(REST);
    rom[4] = rom[3];
    if ($urandom_range(0, 1) == 1) rom[5] = '0;
  endtask

  task automatic idle_chk(int n, int a);
    exp_t e;
    for (int k = 1; k <= n; k++) begin
      e.c = cyc + k;
      e.addr = a;
      e.buz = 1'b0;
      e.bsy = 1'b0;
      e.dn = 1'b0;
      q.push_back(e);
    end
    repeat (n) tick();
  endtask

  // start playback, optionally stop+start together at edge stop_at, optionally start during DONE
  task automatic play(bit lp, int len, int stop_at, bit poke_done);
    int e_s;
    exp_t e, ls;
    tick();
    start = 1'b1;
    loop_en = lp;
    e_s = cyc + 1;
    for (int k = 0; k <= len; k++) begin
      if (stop_at >= 0 && k >= stop_at) begin
        e.c = e_s + k;
        e.addr = ls.addr;
        e.buz = 1'b0;
        e.bsy = 1'b0;
        e.dn = 1'b0;
      end else begin
        e = model(e_s, k, lp);
        ls = e;
      end
      q.push_back(e);
    end
    tick();
    start = 1'b0;
    while (cyc < e_s + len) begin
      if (stop_at >= 0 && cyc == e_s + stop_at - 1) begin
        stop = 1'b1;
        start = 1'b1;
      end else if (poke_done && !lp && cyc == e_s + TOTAL)
        start = 1'b1;
      tick();
      stop = 1'b0;
      start = 1'b0;
    end
  endtask

  initial begin
    #2;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (!rst_n) begin
        n_chk++;
        if (address !== 9'd0 || buzzer !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL reset@%0t got addr=%0d buz=%b busy=%b done=%b, want all 0", $time, address, buzzer, busy, done);
        end
      end else
        while (q.size() > 0 && q[0].c <= cyc) begin
          me = q.pop_front();
          n_chk++;
          if (me.c != cyc || address !== 9'(me.addr) || buzzer !== me.buz || busy !== me.bsy || done !== me.dn) begin
            n_fail++;
            $display("FAIL out@cyc%0d got addr=%0d buz=%b busy=%b done=%b, want (cyc%0d) addr=%0d buz=%b busy=%b done=%b",
                     cyc, address, buzzer, busy, done, me.c, me.addr, me.buz, me.bsy, me.dn);
          end
        end
      if (end_req) begin
        n_chk++;
        if (q.size() != 0) begin
          n_fail++;
          $display("FAIL drain got %0d pending, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k_rst;
    for (int i = 0; i < 512; i++) rom[i] = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    idle_chk(3, 0);
    fill();
    rom[0] = NW'(50);
    rom[1] = NW'(50);
    play(1'b0, TOTAL + 6, -1, 1'b1);
    idle_chk(2, LAST);
    fill();
    play(1'b1, 2 * TOTAL + 250, 2 * TOTAL + 150, 1'b0);
    tick();
    start = 1'b1;
    stop = 1'b1;
    idle_chk(3, (2 * TOTAL + 149) / BEAT % (LAST + 1));
    start = 1'b0;
    stop = 1'b0;
    play(1'b0, 250, -1, 1'b0);
    fill();
    play(1'b0, 149, -1, 1'b0);
    play(1'b0, 400, -1, 1'b0);
    repeat (4) begin
      int len, stp;
      bit lp;
      fill();
      lp = 1'($urandom_range(0, 1));
      len = $urandom_range(300, TOTAL + 20);
      stp = $urandom_range(0, 1) == 1 ? $urandom_range(1, len) : -1;
      play(lp, len, stp, 1'b0);
    end
    fill();
    k_rst = 250;
    for (int k = 250; k < 900; k++) begin
      exp_t e;
      e = model(0, k, 1'b1);
      if (e.buz) begin
        k_rst = k;
        break;
      end
    end
    play(1'b1, k_rst, -1, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    idle_chk(4, 0);
    play(1'b0, 120, -1, 1'b0);
    end_req = 1'b1;
  end
endmodule

// File: doc/music_player.md
MUSIC_PLAYER -- requirements
Module: music_player

Interface
REQ-001 SHALL have parameter BEAT_CYC, default 12_500_000: clock cycles per ROM entry (one eighth-note at 50 MHz).
REQ-002 SHALL have parameter LAST_ADDR, default 383: final ROM address of the score.
REQ-003 SHALL have parameter REST_CODE, default 2500: note_in value that denotes silence.
REQ-004 SHALL have parameter NOTE_W, default 17: width of the note half-period word.
REQ-005 SHALL have port clk, input, 1: the single clock for all state.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1: one-cycle request to begin playback from address 0.
REQ-008 SHALL have port stop, input, 1: one-cycle request to abort playback.
REQ-009 SHALL have port loop_en, input, 1: when 1, playback restarts at address 0 after LAST_ADDR.
REQ-010 SHALL have port address, output, 9: ROM address driven to the note ROM.
REQ-011 SHALL have port note_in, input, NOTE_W: half-period in clk cycles, returned by the ROM one cycle after address.
REQ-012 SHALL have port buzzer, output, 1: square-wave tone output.
REQ-013 SHALL have port busy, output, 1: high in PLAY state.
REQ-014 SHALL have port done, output, 1: one-cycle pulse when a non-looping score ends.

Function
REQ-015 SHALL implement states IDLE, PLAY, DONE.
- IDLE -> PLAY on start.
- PLAY -> IDLE on stop.
- PLAY -> DONE at the end of the beat at LAST_ADDR with loop_en=0.
- DONE -> IDLE after one cycle.
REQ-016 SHALL have stop take priority over start and over the end-of-score transition in the same cycle.
REQ-017 SHALL restart from address 0 with the beat counter cleared when start is asserted in PLAY; start in DONE SHALL be ignored.
REQ-018 SHALL clear address to 0 and the beat counter to 0 on entry to PLAY.
REQ-019 SHALL count BEAT_CYC cycles per entry in PLAY, counting 0..BEAT_CYC-1.
REQ-020 SHALL increment address on the last beat cycle; after LAST_ADDR with loop_en=1 it SHALL wrap to 0 with no gap cycle.
REQ-021 SHALL sample loop_en only on the last beat cycle of LAST_ADDR.
REQ-022 SHALL capture note_in into a period register on the cycle after every address change, including entry to PLAY, accounting for the 1-cycle ROM latency.
REQ-023 SHALL hold buzzer at 0 and clear the tone counter for the whole beat when the captured period equals REST_CODE or 0.
REQ-024 SHALL otherwise toggle buzzer each time the tone counter reaches period-1, then clear the counter, giving frequency f_clk/(2*period).
REQ-025 SHALL continue counting and keep buzzer phase when the new period equals the previous one (tied notes), so no glitch occurs at the beat boundary.
REQ-026 SHALL clear the tone counter and start buzzer at 0 when the new period differs from the previous one.
REQ-027 SHALL generate no tone on the capture cycle itself, so tone starts 2 cycles after the address change.
REQ-028 SHALL force buzzer to 0 and hold address at its last value in IDLE and DONE.
REQ-029 SHALL set busy equal to (state==PLAY), registered.
REQ-030 SHALL assert done for exactly one cycle, coincident with state DONE.
REQ-031 SHALL make the tone counter NOTE_W bits wide, with no overflow for any note_in < 2^NOTE_W.

Reset
REQ-032 SHALL, while rst_n=0, asynchronously force state=IDLE, address=0, beat counter=0, tone counter=0, period=0, buzzer=0, busy=0, done=0.
REQ-033 SHALL enter IDLE on release of reset mid-playback and require a new start.

Verification
REQ-034 SHALL check basic tone: BEAT_CYC=1000, start, note_in=50 constant -> buzzer period 100 clk, first rising edge 52 cycles after start, address steps every 1000 cycles.
REQ-035 SHALL check rest: note_in=2500 at address 7 -> buzzer held 0 for the full beat of address 7; tone resumes at address 8.
REQ-036 SHALL check the end of score: LAST_ADDR=3, loop_en=0 -> after 4 beats a done pulse of 1 cycle, busy falls, buzzer 0, address held at 3.
REQ-037 SHALL check loop: LAST_ADDR=3, loop_en=1 -> address sequence 0,1,2,3,0,1 with no extra cycle at the wrap and done never asserted.
REQ-038 SHALL check stop and start together: stop and start in the same PLAY cycle -> IDLE next cycle, buzzer 0; a later start alone -> address 0, busy 1.
REQ-039 SHALL check tied notes and reset: equal note_in values across a beat boundary -> no phase reset of buzzer; rst_n low mid-tone -> all outputs 0 immediately, without waiting for clk.
